// File: rtl/bp_pkg.sv
// Shared types for the branch prediction queue: entry layout, flush FSM states,
// and instruction size used for fall-through redirect.
package bp_pkg;

    localparam int BPQ_XLEN       = 32;
    localparam int BPQ_INSN_BYTES = 4;

    typedef struct packed {
        logic [BPQ_XLEN-1:0] pc;
        logic                taken;
        logic [BPQ_XLEN-1:0] target;
    } bpq_entry_t;

    typedef enum logic {
        BPQ_RUN   = 1'b0,
        BPQ_FLUSH = 1'b1
    } bpq_state_t;

endpackage

// File: rtl/branch_pred_queue.sv
// In-order queue of in-flight branch predictions between fetch and EX resolution.
// Optional BPQ_STATS_EN adds saturating branch/mispredict counters.
module branch_pred_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = BPQ_XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_en,
    input  logic [XLEN-1:0]          push_pc,
    input  logic                     push_taken,
    input  logic [XLEN-1:0]          push_target,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     pop_en,
    input  logic [XLEN-1:0]          ex_pc,
    input  logic                     ex_taken,
    input  logic [XLEN-1:0]          ex_target,
    output logic                     mispredict,
    output logic [XLEN-1:0]          redirect_pc,
    output logic                     train_en,
    output logic                     train_taken,
    output logic                     order_err,
`ifdef BPQ_STATS_EN
    output logic [31:0]              stat_branches,
    output logic [31:0]              stat_mispredicts,
`endif
    output bpq_state_t               state_dbg
);

    localparam int PW = $clog2(DEPTH);

    // Handshake: a push is taken on any clk edge where push_en is high, the queue
    // has room (or a pop frees the head that cycle), the FSM is in RUN and the same
    // cycle is not a mispredicting pop; a pop is taken whenever pop_en is high and
    // the queue is not empty. There is no backpressure beyond full/empty.

    logic [XLEN-1:0] pc_mem_q  [DEPTH];
    logic            tkn_mem_q [DEPTH];
    logic [XLEN-1:0] tgt_mem_q [DEPTH];

    logic [PW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            mispredict_q, mispredict_d;
    logic [XLEN-1:0] redirect_q, redirect_d;
    logic            train_en_q, train_en_d;
    logic            train_taken_q, train_taken_d;
    logic            order_err_q, order_err_d;
    bpq_state_t      state_q, state_d;

    logic            full_w, empty_w, pop_acc, push_acc, miss;
    logic [XLEN-1:0] head_pc, head_tgt;
    logic            head_taken;

    assign full_w  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty_w = (wr_ptr_q == rd_ptr_q);

    always_comb begin
        head_pc    = pc_mem_q[rd_ptr_q[PW-1:0]];
        head_taken = tkn_mem_q[rd_ptr_q[PW-1:0]];
        head_tgt   = tgt_mem_q[rd_ptr_q[PW-1:0]];
        pop_acc    = pop_en && !empty_w;
        miss       = pop_acc && ((head_taken != ex_taken) || (ex_taken && (head_tgt != ex_target)));
        push_acc   = push_en && (!full_w || pop_acc) && (state_q == BPQ_RUN) && !miss;

        rd_ptr_d = rd_ptr_q + (PW+1)'(pop_acc);
        // A mispredict discards every entry younger than the resolving branch.
        wr_ptr_d = miss ? rd_ptr_q + (PW+1)'(1) : wr_ptr_q + (PW+1)'(push_acc);

        mispredict_d  = miss;
        redirect_d    = redirect_q;
        train_taken_d = train_taken_q;
        if (pop_acc) begin
            redirect_d    = ex_taken ? ex_target : ex_pc + XLEN'(BPQ_INSN_BYTES);
            train_taken_d = ex_taken;
        end
        train_en_d  = pop_acc;
        order_err_d = order_err_q || (pop_en && empty_w) || (pop_acc && (head_pc != ex_pc));

        state_d = state_q;
        case (state_q)
            BPQ_RUN:   state_d = miss ? BPQ_FLUSH : BPQ_RUN;
            BPQ_FLUSH: state_d = BPQ_RUN;
            default:   state_d = BPQ_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            pc_mem_q[wr_ptr_q[PW-1:0]]  <= push_pc;
            tkn_mem_q[wr_ptr_q[PW-1:0]] <= push_taken;
            tgt_mem_q[wr_ptr_q[PW-1:0]] <= push_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mispredict_q  <= 1'b0;
            redirect_q    <= '0;
            train_en_q    <= 1'b0;
            train_taken_q <= 1'b0;
            order_err_q   <= 1'b0;
            state_q       <= BPQ_RUN;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mispredict_q  <= mispredict_d;
            redirect_q    <= redirect_d;
            train_en_q    <= train_en_d;
            train_taken_q <= train_taken_d;
            order_err_q   <= order_err_d;
            state_q       <= state_d;
        end
    end

`ifdef BPQ_STATS_EN
    logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (pop_acc && (stat_br_q != '1)) stat_br_d = stat_br_q + 32'd1;
        if (miss && (stat_mp_q != '1))    stat_mp_d = stat_mp_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif

    assign full        = full_w;
    assign empty       = empty_w;
    assign count       = wr_ptr_q - rd_ptr_q;
    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_q;
    assign train_en    = train_en_q;
    assign train_taken = train_taken_q;
    assign order_err   = order_err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_branch_pred_queue.sv
// Testbench for branch_pred_queue: directed steps followed by random traffic,
// all checked against a queue-based reference model.
module tb_branch_pred_queue;
    import bp_pkg::*;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            push_en = 1'b0, push_taken = 1'b0, pop_en = 1'b0, ex_taken = 1'b0;
    logic [XLEN-1:0] push_pc = '0, push_target = '0, ex_pc = '0, ex_target = '0;
    logic            full, empty, mispredict, train_en, train_taken, order_err;
    logic [3:0]      count;
    logic [XLEN-1:0] redirect_pc;
    bpq_state_t      state_dbg;
`ifdef BPQ_STATS_EN
    logic [31:0]     stat_branches, stat_mispredicts;
`endif

    branch_pred_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .push_en(push_en), .push_pc(push_pc), .push_taken(push_taken), .push_target(push_target),
        .full(full), .empty(empty), .count(count),
        .pop_en(pop_en), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .train_en(train_en), .train_taken(train_taken), .order_err(order_err),
`ifdef BPQ_STATS_EN
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] tgt;
    } ent_t;

    ent_t            mq[$];
    logic            m_flush, m_misp, m_train_en, m_train_taken, m_err;
    logic [XLEN-1:0] m_redirect;
    int unsigned     m_stat_br, m_stat_mp;
    int              checks = 0;
    int              fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_flush = 0; m_misp = 0; m_train_en = 0; m_train_taken = 0; m_err = 0;
        m_redirect = '0; m_stat_br = 0; m_stat_mp = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_count"}, 64'(count), 64'(mq.size()));
        check({tag, "_full"},  64'(full),  64'(mq.size() == DEPTH));
        check({tag, "_empty"}, 64'(empty), 64'(mq.size() == 0));
        check({tag, "_misp"},  64'(mispredict), 64'(m_misp));
        check({tag, "_train_en"}, 64'(train_en), 64'(m_train_en));
        check({tag, "_order_err"}, 64'(order_err), 64'(m_err));
        check({tag, "_state"}, 64'(state_dbg), 64'(m_flush ? BPQ_FLUSH : BPQ_RUN));
        if (m_misp) check({tag, "_redirect"}, 64'(redirect_pc), 64'(m_redirect));
        if (m_train_en) check({tag, "_train_taken"}, 64'(train_taken), 64'(m_train_taken));
`ifdef BPQ_STATS_EN
        check({tag, "_stat_br"}, 64'(stat_branches), 64'(m_stat_br));
        check({tag, "_stat_mp"}, 64'(stat_mispredicts), 64'(m_stat_mp));
`endif
    endtask

    // One clock: drive at negedge, advance the model, check #1 after posedge.
    task automatic step(input string tag,
                        input logic pe, input logic [XLEN-1:0] ppc, input logic pt, input logic [XLEN-1:0] ptg,
                        input logic po, input logic [XLEN-1:0] epc, input logic et, input logic [XLEN-1:0] etg);
        bit   was_full, pop_ok, miss, push_ok;
        ent_t h, e;
        @(negedge clk);
        push_en = pe; push_pc = ppc; push_taken = pt; push_target = ptg;
        pop_en = po; ex_pc = epc; ex_taken = et; ex_target = etg;

        was_full = (mq.size() == DEPTH);
        pop_ok   = po && (mq.size() != 0);
        miss     = 0;
        if (po && mq.size() == 0) m_err = 1;
        if (pop_ok) begin
            h = mq.pop_front();
            miss = (h.taken != et) || (et && (h.tgt != etg));
            if (h.pc != epc) m_err = 1;
            m_redirect    = et ? etg : epc + 32'd4;
            m_train_taken = et;
            if (m_stat_br != 32'hFFFF_FFFF) m_stat_br++;
            if (miss && m_stat_mp != 32'hFFFF_FFFF) m_stat_mp++;
        end
        push_ok = pe && !m_flush && (!was_full || pop_ok) && !miss;
        if (miss) mq.delete();
        if (push_ok) begin
            e.pc = ppc; e.taken = pt; e.tgt = ptg;
            mq.push_back(e);
        end
        m_misp     = miss;
        m_train_en = pop_ok;
        m_flush    = miss;

        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, '0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        push_en = 0; pop_en = 0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("por");
        do_reset();

        // Correct not-taken prediction.
        step("t1_push", 1, 32'h10, 0, '0, 0, '0, 0, '0);
        step("t1_pop",  0, '0, 0, '0, 1, 32'h10, 0, '0);
        check("t1_empty", 64'(empty), 64'd1);

        // Predicted not-taken, actually taken.
        step("t2_push", 1, 32'h20, 0, '0, 0, '0, 0, '0);
        step("t2_pop",  0, '0, 0, '0, 1, 32'h20, 1, 32'h40);
        check("t2_redirect", 64'(redirect_pc), 64'h40);
        check("t2_flush", 64'(state_dbg), 64'(BPQ_FLUSH));
        idle("t2_after");

        // Predicted taken, actually not-taken: fall-through redirect.
        step("t3_push", 1, 32'h30, 1, 32'h80, 0, '0, 0, '0);
        step("t3_pop",  0, '0, 0, '0, 1, 32'h30, 0, '0);
        check("t3_redirect", 64'(redirect_pc), 64'h34);
        idle("t3_after");

        // Fill, overflow push, simultaneous push+pop at full, then drain.
        for (int i = 0; i < DEPTH; i++) step("t4_fill", 1, 32'h100 + 32'(4*i), 0, '0, 0, '0, 0, '0);
        check("t4_full", 64'(full), 64'd1);
        step("t4_over", 1, 32'h200, 0, '0, 0, '0, 0, '0);
        check("t4_count_over", 64'(count), 64'd8);
        step("t4_pushpop", 1, 32'h300, 0, '0, 1, 32'h100, 0, '0);
        check("t4_count_pp", 64'(count), 64'd8);
        while (mq.size() != 0) step("t4_drain", 0, '0, 0, '0, 1, mq[0].pc, mq[0].taken, mq[0].tgt);

        // Mispredict flushes younger entries; push during flush is dropped.
        step("t5_p0", 1, 32'h10, 0, '0, 0, '0, 0, '0);
        step("t5_p1", 1, 32'h14, 0, '0, 0, '0, 0, '0);
        step("t5_p2", 1, 32'h18, 0, '0, 0, '0, 0, '0);
        step("t5_miss", 1, 32'h1c, 0, '0, 1, 32'h10, 1, 32'h50);
        check("t5_empty", 64'(empty), 64'd1);
        step("t5_flushpush", 1, 32'h20, 0, '0, 0, '0, 0, '0);
        check("t5_dropped", 64'(count), 64'd0);

        // Async reset asserted mid-cycle while in FLUSH.
        step("t6_push", 1, 32'h40, 0, '0, 0, '0, 0, '0);
        step("t6_miss", 0, '0, 0, '0, 1, 32'h40, 1, 32'h90);
        #2;
        rst = 0;
        model_reset();
        #1;
        check("t6_async_state", 64'(state_dbg), 64'(BPQ_RUN));
        check("t6_async_misp", 64'(mispredict), 64'd0);
        check_all("t6_async");
        @(negedge clk);
        rst = 1;

        // Pop while empty sets sticky order_err.
        step("t7_pop_empty", 0, '0, 0, '0, 1, 32'h60, 1, 32'h70);
        check("t7_err", 64'(order_err), 64'd1);
        idle("t7_sticky0");
        step("t7_sticky1", 1, 32'h64, 0, '0, 0, '0, 0, '0);
        idle("t7_sticky2");
        do_reset();
        check("t7_err_cleared", 64'(order_err), 64'd0);

        // Random traffic; mostly in-order pops with occasional wrong PC/target.
        for (int n = 0; n < 600; n++) begin
            logic            pe, pt, po, et;
            logic [XLEN-1:0] ppc, ptg, epc, etg;
            pe  = 1'($urandom_range(0, 1));
            ppc = {$urandom_range(0, 255), 2'b00};
            pt  = 1'($urandom_range(0, 1));
            ptg = {$urandom_range(0, 255), 2'b00};
            if (mq.size() != 0) begin
                po  = ($urandom_range(0, 2) != 0);
                epc = ($urandom_range(0, 31) == 0) ? ppc ^ 32'h4 : mq[0].pc;
                et  = ($urandom_range(0, 7) == 0) ? ~mq[0].taken : mq[0].taken;
                etg = ($urandom_range(0, 7) == 0) ? mq[0].tgt + 32'h8 : mq[0].tgt;
            end else begin
                po  = ($urandom_range(0, 39) == 0);
                epc = ppc; et = pt; etg = ptg;
            end
            step("rnd", pe, ppc, pt, ptg, po, epc, et, etg);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
